// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// Holds opcode constants, the 4-bit control state encoding, and the
// ALU-op / pc_src / alu_src_b select encodings used by the datapath and
// ALU control. No ports (package).
package mips_ctrl_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_SLT   = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_B_RT      = 2'd0,
    ALU_B_FOUR    = 2'd1,
    ALU_B_SEXT    = 2'd2,
    ALU_B_SEXT_SH = 2'd3
  } alu_src_b_e;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of a multi-cycle MIPS-subset core with a shared ALU and a
// unified variable-latency instruction/data memory (req/ready handshake).
// Ports:
//   clk_i, rst_i (sync, active high), en_i (run enable, low freezes)
//   opcode_i[5:0] from IR, zero_i ALU flag, mem_ready_i memory done
//   mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o[1:0]
//   alu_src_a_o, alu_src_b_o[1:0], alu_op_o[2:0], reg_dst_o, mem_to_reg_o,
//   reg_write_o, illegal_o / retire_o pulses, instr_count_o[CNT_W-1:0],
//   state_o[3:0] debug view of the state register.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instr_count_o,
  output logic [3:0]       state_o
);

  state_e           state_r;
  state_e           next_state_s;
  logic [CNT_W-1:0] count_r;

  // Ungated enables/requests/pulses from the state decode
  logic mem_read_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;
  logic illegal_s, retire_s;
  logic active_s;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // State register and retired-instruction counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_FETCH;
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (en_i) begin
        state_r <= next_state_s;
      end else begin
        state_r <= state_r;
      end
      // retire_o is already gated by en_i, so a frozen FSM never counts
      if (retire_o) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    iord_o       = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALU_B_RT;
    alu_op_o     = ALU_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;

    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_o = ALU_B_FOUR;
        // The read request is held until memory completes it
        if (mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut
        alu_src_b_o = ALU_B_SEXT_SH;
        case (opcode_i)
          OP_LW, OP_SW:     next_state_s = S_MEM_ADDR;
          OP_RTYPE:         next_state_s = S_R_EXEC;
          OP_ADDI, OP_SLTI: next_state_s = S_I_EXEC;
          OP_BEQ, OP_BNE:   next_state_s = S_BRANCH;
          OP_J:             next_state_s = S_JUMP;
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_SEXT;
        if (opcode_i == OP_LW) begin
          next_state_s = S_MEM_READ;
        end else if (opcode_i == OP_SW) begin
          next_state_s = S_MEM_WRITE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_FUNCT;
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_o    = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_SEXT;
        if (opcode_i == OP_SLTI) begin
          alu_op_o = ALU_SLT;
        end else begin
          alu_op_o = ALU_ADD;
        end
        next_state_s = S_I_WB;
      end
      S_I_WB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        if (opcode_i == OP_BNE) begin
          pc_write_s = ~zero_i;
        end else begin
          pc_write_s = zero_i;
        end
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_src_o     = PC_SRC_JUMP;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Side-effecting outputs are suppressed in reset and while frozen; a
  // withdrawn memory request is simply reissued once en_i returns.
  always_comb begin
    active_s = en_i & ~rst_i;
    if (active_s) begin
      mem_read_o  = mem_read_s;
      mem_write_o = mem_write_s;
      ir_write_o  = ir_write_s;
      pc_write_o  = pc_write_s;
      reg_write_o = reg_write_s;
      illegal_o   = illegal_s;
      retire_o    = retire_s;
    end else begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
      retire_o    = 1'b0;
    end
  end

  assign instr_count_o = count_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, zero, mem_ready;
  logic [5:0]    opcode;
  logic          mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]    pc_src, alu_src_b;
  logic          alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, retire;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_count;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .iord_o(iord), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .pc_src_o(pc_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .reg_write_o(reg_write), .illegal_o(illegal), .retire_o(retire),
    .instr_count_o(instr_count), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; opcode = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++;
    if (instr_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    vectors++;
    if ({mem_read, ir_write, pc_write, retire} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_enables: got %b expected 0000", {mem_read, ir_write, pc_write, retire});
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({mem_read, iord, alu_src_b, ir_write} !== 5'b1_0_01_0) begin
      miscompares++; $display("FAIL fetch_outputs: got %b expected 10010", {mem_read, iord, alu_src_b, ir_write});
    end
    exp_count = 4'd0;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (state !== exp_st[i]) begin miscompares++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
      vectors++;
      if ({reg_write, reg_dst, retire} !== {3{i == 3}}) begin
        miscompares++; $display("FAIL rtype_wb[%0d]: got %b expected %b", i, {reg_write, reg_dst, retire}, {3{i == 3}});
      end
      if (i == 2) begin
        vectors++;
        if (alu_op !== 3'd2) begin miscompares++; $display("FAIL rtype_aluop: got %0d expected 2", alu_op); end
      end
      tick();
    end
    exp_count = exp_count + 4'd1;
    vectors++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      miscompares++; $display("FAIL rtype_end: got state %0d count %0d expected 0 %0d", state, instr_count, exp_count);
    end
  endtask

  task automatic test_lw_stalls();
    logic [3:0] exp_st [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy    [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] exp_o;
    opcode = OP_LW;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      // {mem_read, iord, ir_write, mem_to_reg, reg_write, retire}
      exp_o = {(i < 4) || (i >= 6 && i <= 8), (i >= 6 && i <= 8), i == 3, i == 9, i == 9, i == 9};
      vectors++;
      if (state !== exp_st[i]) begin miscompares++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
      vectors++;
      if ({mem_read, iord, ir_write, mem_to_reg, reg_write, retire} !== exp_o) begin
        miscompares++; $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, {mem_read, iord, ir_write, mem_to_reg, reg_write, retire}, exp_o);
      end
      tick();
    end
    exp_count = exp_count + 4'd1;
    vectors++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      miscompares++; $display("FAIL lw_end: got state %0d count %0d expected 0 %0d", state, instr_count, exp_count);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2] = '{OP_BEQ, OP_BNE};
    mem_ready = 1'b1; zero = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      tick(); tick();
      vectors++;
      if (state !== 4'd8) begin miscompares++; $display("FAIL branch_state[%0d]: got %0d expected 8", k, state); end
      vectors++;
      if ({pc_write, pc_src, alu_op, retire} !== {k == 0, 2'd1, 3'd1, 1'b1}) begin
        miscompares++; $display("FAIL branch_ctrl[%0d]: got %b expected %b", k, {pc_write, pc_src, alu_op, retire}, {k == 0, 2'd1, 3'd1, 1'b1});
      end
      tick();
    end
    zero = 1'b0;
    exp_count = exp_count + 4'd2;
    vectors++;
    if (instr_count !== exp_count) begin miscompares++; $display("FAIL branch_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    vectors++;
    if ({state, illegal, retire} !== {4'd1, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL illegal_decode: got %b expected %b", {state, illegal, retire}, {4'd1, 1'b1, 1'b0});
    end
    tick();
    vectors++;
    if ({state, illegal, instr_count} !== {4'd0, 1'b0, exp_count}) begin
      miscompares++; $display("FAIL illegal_after: got %b expected %b", {state, illegal, instr_count}, {4'd0, 1'b0, exp_count});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [4] = '{OP_ADDI, OP_SLTI, OP_J, OP_SW};
    int         cpi  [4] = '{4, 4, 3, 4};
    int         cycles;
    logic       done;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; cycles = 0; done = 1'b0;
      while (!done && cycles < 20) begin
        #1;
        if (retire) done = 1'b1;
        if (state == 4'd10) begin
          vectors++;
          if (alu_op !== ((k == 1) ? 3'd3 : 3'd0)) begin
            miscompares++; $display("FAIL iexec_aluop[%0d]: got %0d expected %0d", k, alu_op, (k == 1) ? 3 : 0);
          end
        end
        cycles++;
        tick();
      end
      vectors++;
      if (!done || cycles != cpi[k]) begin
        miscompares++; $display("FAIL cpi[%0d]: got %0d cycles (retired %0b) expected %0d", k, cycles, done, cpi[k]);
      end
    end
    exp_count = exp_count + 4'd4;
    vectors++;
    if (instr_count !== exp_count) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", instr_count, exp_count); end
  endtask

  task automatic test_enable_pause();
    opcode = OP_RTYPE; mem_ready = 1'b1; en = 1'b0;
    #1;
    vectors++;
    if ({state, mem_read, ir_write, pc_write} !== {4'd0, 3'b000}) begin
      miscompares++; $display("FAIL pause_fetch: got %b expected %b", {state, mem_read, ir_write, pc_write}, {4'd0, 3'b000});
    end
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({state, mem_read, mem_write, ir_write, pc_write, reg_write, retire, illegal} !== {4'd6, 7'd0}) begin
        miscompares++; $display("FAIL pause_hold[%0d]: got %b expected %b", i, {state, mem_read, mem_write, ir_write, pc_write, reg_write, retire, illegal}, {4'd6, 7'd0});
      end
      tick();
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({state, reg_write, retire} !== {4'd7, 2'b11}) begin
      miscompares++; $display("FAIL resume_wb: got %b expected %b", {state, reg_write, retire}, {4'd7, 2'b11});
    end
    tick();
    exp_count = exp_count + 4'd1;
    vectors++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      miscompares++; $display("FAIL resume_end: got state %0d count %0d expected 0 %0d", state, instr_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    vectors++;
    if ({state, mem_write, iord} !== {4'd5, 2'b11}) begin
      miscompares++; $display("FAIL sw_wait: got %b expected %b", {state, mem_write, iord}, {4'd5, 2'b11});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({mem_write, retire, reg_write, pc_write} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mid_enables: got %b expected 0000", {mem_write, retire, reg_write, pc_write});
    end
    tick();
    rst = 1'b0;
    exp_count = 4'd0;
    vectors++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      miscompares++; $display("FAIL reset_mid_after: got state %0d count %0d expected 0 0", state, instr_count);
    end
  endtask

  task automatic test_wrap();
    opcode = OP_J; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick();
      exp_count = exp_count + 4'd1;
      if (i == 14 || i == 15) begin
        vectors++;
        if (instr_count !== exp_count) begin
          miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, instr_count, exp_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stalls();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_enable_pause();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
